softplus_sq_sched: RTL and testbench
====================================

Name: softplus_sq_sched

Overview:
- Shares one combinational softplus_squared unit between N_REQ requesters, e.g. the per-latent-dimension variance paths of the VAE encoder.
- Arbitrates requests round-robin and clamps each operand to the characterised input range [-7.0, +7.0] in Q8.8.
- Registers the operand before the unit and registers the result after it.
- Returns each result on a single tagged output stream with valid/ready backpressure. Peak throughput is one result per cycle.

Parameters:
- WIDTH, 16, operand/result width, signed fixed point.
- FRAC, 8, fractional bits (0x0100 = 1.0).
- N_REQ, 4, number of requesters (2..16).
- TAG_W, clog2(N_REQ), width of the requester tag.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_data  in  N_REQ*WIDTH  packed signed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  softplus(x)^2 of the clamped operand.
- out_tag  out  TAG_W  index of the requester that produced the result.
- out_sat  out  1  operand was clamped.
- sat_count  out  16  number of clamped operands accepted since reset; saturates at 0xFFFF.
- sat_clr  in  1  synchronous clear of sat_count.

Behaviour:
- Reset (rst low, asynchronous): s1_valid = 0, out_valid = 0, out_data = 0, out_tag = 0, out_sat = 0, sat_count = 0, round-robin pointer = 0. Any in-flight operands are discarded. Deasserting reset mid-stream leaves the block idle; no stale result is ever presented.
- Pipeline: S1 register (operand, tag, sat) feeds softplus_squared combinationally; the result is captured into S2 (out_* registers).
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
- Grant: combinational round-robin over req_valid, starting the search at the pointer index.
  - req_ready[g] = adv1 & grant[g].
  - req_ready may depend on req_valid (handshake completes on valid & ready).
- Handshake on requester g in cycle t:
  - req_data[g] is clamped, then captured into S1 with tag = g.
  - Pointer becomes (g+1) mod N_REQ.
  - Without an accept the pointer holds.
- Latency: handshake in cycle t gives out_valid in cycle t+2 when out_ready is held high. A continuously valid requester set produces back-to-back results with no bubbles.
- Backpressure:
  - While out_valid = 1 and out_ready = 0, S2 holds.
  - S1 may still fill while S2 is stalled.
  - Once S1 is full, all req_ready bits are low.
  - No result is lost or duplicated.
  - S2 reloads from S1 only when adv2 = 1; an empty S1 clears out_valid.
- Clamp (signed compare):
  - x < 0xF900 gives 0xF900.
  - x > 0x0700 gives 0x0700.
  - Otherwise x passes unchanged.
  - out_sat = 1 iff the value changed. Boundary values 0xF900 and 0x0700 pass unclamped with sat = 0.
- sat_count increments by 1 on each accepted clamped operand and holds at 0xFFFF.
  - sat_clr has priority: clear and increment in the same cycle gives 0.
- Simultaneous requests: exactly one grant per cycle. Starvation-free; each valid requester is served within N_REQ accepts.
- A requester that drops req_valid before ready is not granted. Requesters are not required to hold the operand stable; only the value at the handshake is used.
- Arithmetic is purely the existing unit's function. The block adds no rounding, and out_data width equals WIDTH.

Decomposition:
- Package softplus_pkg holds:
  - WIDTH and FRAC.
  - X_MIN = 16'hF900 and X_MAX = 16'h0700.
  - A clamp function returning the clamped value and the sat flag.
  - A function computing TAG_W from N_REQ.
- Sub-module rr_arbiter (N parameter):
  - Inputs: req[N], accept, clock, rst.
  - Outputs: one-hot grant[N] and the encoded index.
  - Holds the rotating pointer.
- Top instantiates rr_arbiter and the existing softplus_squared unchanged (operand/out ports).

Test Plan:
- Single request: requester 2 sends 0x0000 with out_ready = 1. Expect out_valid two cycles after the handshake, out_tag = 2, out_sat = 0, and out_data equal to a standalone softplus_squared at 0x0000 (ideal 0x007B).
- All four requesters continuously valid with operands 0x0100, 0x0200, 0xFF00, 0xFE00 and out_ready = 1. Expect grant order 0,1,2,3,0,… one accept per cycle, and tags/results in the same order.
- Clamp: send 0x8000, 0xF8FF, 0xF900, 0x0700, 0x0701, 0x7FFF. Expect effective inputs 0xF900, 0xF900, 0xF900, 0x0700, 0x0700, 0x0700, out_sat = 1,1,0,0,1,1, and sat_count = 4.
- Backpressure: stream from requester 0 while holding out_ready = 0 for 5 cycles. Expect exactly 2 accepts, then all req_ready low. On releasing out_ready, both results emerge in order with no loss or duplication.
- Reset mid-operation: pull rst low with S1 and S2 full. Expect out_valid = 0 and sat_count = 0 immediately (asynchronous). After release, a request to requester 3 is granted before requester 1 only if the pointer index order makes it first after reset to 0.
- sat_clr: assert sat_clr in the same cycle as a clamped accept. Expect sat_count = 0 next cycle. Separately, force 65536+ clamps and expect sat_count to hold at 0xFFFF.

Source files
------------

// File: rtl/softplus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : softplus_pkg
// Description : Shared Q8.8 format constants, the characterised input window
//               of softplus_squared, an operand clamp helper and a tag-width
//               helper for the softplus_sq_sched slice.
// Revision    : 1.0 - initial release
// ============================================================================
package softplus_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  // Characterised input window of softplus_squared: [-7.0, +7.0] in Q8.8.
  localparam logic [WIDTH-1:0] X_MIN = 16'hF900;
  localparam logic [WIDTH-1:0] X_MAX = 16'h0700;

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             sat;
  } clamp_t;

  // Signed clamp into [X_MIN, X_MAX]; sat flags that the value was changed.
  // The window edges themselves pass through untouched.
  function automatic clamp_t clamp(input logic [WIDTH-1:0] x);
    clamp_t r;
    r.val = x;
    r.sat = 1'b0;
    if ($signed(x) < $signed(X_MIN)) begin
      r.val = X_MIN;
      r.sat = 1'b1;
    end else if ($signed(x) > $signed(X_MAX)) begin
      r.val = X_MAX;
      r.sat = 1'b1;
    end
    return r;
  endfunction

  // Bits needed to encode an index in 0..n-1, never less than one.
  function automatic int tag_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 30; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/softplus_sq_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. The search for a requester starts at
//               the rotating pointer; on an accepted grant the pointer moves
//               to the slot after the winner, otherwise it holds.
// Ports       : clock  - rising-edge clock
//               rst    - asynchronous active-low reset (pointer to 0)
//               req    - request vector
//               accept - the current grant is being consumed this cycle
//               grant  - one-hot grant (zero when no request)
//               idx    - encoded index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = softplus_pkg::tag_width(N)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  logic [IW-1:0] w_i;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_i     = '0;
    for (int k = 0; k < N; k++) begin
      w_i = IW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_i]) begin
        w_found    = 1'b1;
        grant[w_i] = 1'b1;
        idx        = w_i;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (accept && w_found) begin
      r_ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/softplus_squared.sv
`default_nettype none
// ============================================================================
// Module      : softplus_squared
// Description : Combinational softplus(x)^2 in Q8.8. Piecewise-linear
//               interpolation between knots at every integer x in [-7, +7];
//               inputs outside the window are held at the nearest knot.
// Ports       : operand - signed Q8.8 input
//               out     - softplus(operand)^2, Q8.8
// Revision    : 1.0 - initial release
// ============================================================================
module softplus_squared #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] out
);

  // Offset that maps x = -7.0 to zero, and the width of the whole window.
  localparam logic signed [WIDTH:0] c_off  = (WIDTH+1)'(7 << FRAC);
  localparam logic signed [WIDTH:0] c_span = (WIDTH+1)'(14 << FRAC);

  // round(256 * ln(1 + e^x)^2) at x = -7 .. +7. Index 15 repeats the last
  // knot so the x = +7.0 lookup has a zero-slope neighbour.
  function automatic logic [WIDTH-1:0] knot(input logic [3:0] k);
    logic [WIDTH-1:0] v;
    case (k)
      4'd0:    v = WIDTH'(0);
      4'd1:    v = WIDTH'(0);
      4'd2:    v = WIDTH'(0);
      4'd3:    v = WIDTH'(0);
      4'd4:    v = WIDTH'(1);
      4'd5:    v = WIDTH'(4);
      4'd6:    v = WIDTH'(25);
      4'd7:    v = WIDTH'(123);
      4'd8:    v = WIDTH'(442);
      4'd9:    v = WIDTH'(1158);
      4'd10:   v = WIDTH'(2379);
      4'd11:   v = WIDTH'(4133);
      4'd12:   v = WIDTH'(6417);
      4'd13:   v = WIDTH'(9224);
      default: v = WIDTH'(12547);
    endcase
    return v;
  endfunction

  logic signed [WIDTH:0]      w_off;
  logic [3:0]                 w_idx;
  logic [FRAC-1:0]            w_frac;
  logic [WIDTH-1:0]           w_base;
  logic [WIDTH-1:0]           w_next;
  logic [WIDTH-1:0]           w_diff;
  logic [WIDTH+FRAC-1:0]      w_prod;

  always_comb begin
    w_off  = $signed({operand[WIDTH-1], operand}) + c_off;
    w_idx  = 4'd0;
    w_frac = '0;
    if (w_off[WIDTH]) begin
      w_idx  = 4'd0;
      w_frac = '0;
    end else if (w_off >= c_span) begin
      w_idx  = 4'd14;
      w_frac = '0;
    end else begin
      w_idx  = w_off[FRAC+3:FRAC];
      w_frac = w_off[FRAC-1:0];
    end
    w_base = knot(w_idx);
    w_next = knot(w_idx + 4'd1);
    // Knots are monotonic, so the segment slope is never negative.
    w_diff = w_next - w_base;
    w_prod = (WIDTH+FRAC)'(w_diff) * (WIDTH+FRAC)'(w_frac);
    out    = w_base + WIDTH'(w_prod >> FRAC);
  end

endmodule
`default_nettype wire

// File: rtl/softplus_sq_sched.sv
`default_nettype none
// ============================================================================
// Module      : softplus_sq_sched
// Description : Shares one softplus_squared unit between N_REQ requesters.
//               Round-robin grant, operand clamp to [-7, +7], operand register
//               (S1) ahead of the unit and result register (S2) behind it, and
//               one tagged valid/ready result stream.
// Ports       : clock      - rising-edge clock
//               rst        - asynchronous active-low reset
//               req_valid  - per-requester operand valid
//               req_ready  - per-requester accept, at most one bit high
//               req_data   - packed operands, requester i at [i*WIDTH +: WIDTH]
//               out_valid  - result valid
//               out_ready  - downstream accept
//               out_data   - softplus(x)^2 of the clamped operand
//               out_tag    - requester index of the result
//               out_sat    - operand was clamped
//               sat_count  - clamped accepts since reset, saturating
//               sat_clr    - synchronous clear of sat_count
// Revision    : 1.0 - initial release
// ============================================================================
module softplus_sq_sched #(
  parameter int WIDTH = softplus_pkg::WIDTH,
  parameter int FRAC  = softplus_pkg::FRAC,
  parameter int N_REQ = 4,
  parameter int TAG_W = softplus_pkg::tag_width(N_REQ)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_sat,
  output logic [15:0]            sat_count,
  input  logic                   sat_clr
);

  import softplus_pkg::*;

  logic              w_adv1;
  logic              w_adv2;
  logic              w_acc;
  logic [N_REQ-1:0]  w_grant;
  logic [TAG_W-1:0]  w_gidx;
  logic [WIDTH-1:0]  w_sel;
  clamp_t            w_clamp;
  logic [WIDTH-1:0]  w_sp;

  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_data;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s1_sat;

  // S2 moves when it is empty or being drained; S1 moves when it is empty
  // or S2 is taking its contents this cycle.
  assign w_adv2 = !out_valid || out_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  // The arbiter only grants a requester that is valid, so any valid request
  // while S1 can move is a completed handshake on the granted requester.
  assign w_acc  = w_adv1 && (|req_valid);

  rr_arbiter #(
    .N  (N_REQ),
    .IW (TAG_W)
  ) u_arb (
    .clock  (clock),
    .rst    (rst),
    .req    (req_valid),
    .accept (w_acc),
    .grant  (w_grant),
    .idx    (w_gidx)
  );

  assign req_ready = w_grant & {N_REQ{w_adv1}};
  assign w_sel     = req_data[int'(w_gidx)*WIDTH +: WIDTH];
  assign w_clamp   = clamp(w_sel);

  // S1: clamped operand, tag and clamp flag.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
      r_s1_sat   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_data <= w_clamp.val;
        r_s1_tag  <= w_gidx;
        r_s1_sat  <= w_clamp.sat;
      end
    end
  end

  softplus_squared #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_sp (
    .operand (r_s1_data),
    .out     (w_sp)
  );

  // S2: output registers. An empty S1 drops out_valid; payload is left as is.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= w_sp;
        out_tag  <= r_s1_tag;
        out_sat  <= r_s1_sat;
      end
    end
  end

  // Clamp statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (w_acc && w_clamp.sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_softplus_sq_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_softplus_sq_sched
// Description : Scoreboard bench for softplus_sq_sched. Accepted operands push
//               their expected result; a monitor pops and compares each result
//               the block delivers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softplus_sq_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TW = 2;

  logic           clock = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [TW-1:0]  out_tag;
  logic           out_sat;
  logic [15:0]    sat_count;
  logic           sat_clr = 1'b0;

  softplus_sq_sched #(
    .WIDTH (W),
    .FRAC  (8),
    .N_REQ (N),
    .TAG_W (TW)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
    logic          sat;
    int            hs_cyc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  int   acc_tags[$];
  int   acc_cycs[$];
  int   acc_total = 0;
  int   out_count = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Operand seen by the unit after clamping to [-7.0, +7.0].
  function automatic logic [15:0] eff_in(input logic [15:0] x);
    if ($signed(x) < $signed(16'hF900)) return 16'hF900;
    if ($signed(x) > $signed(16'h0700)) return 16'h0700;
    return x;
  endfunction

  // Hand-computed round(256 * ln(1+e^x)^2) at the effective inputs used here;
  // 0x0080 is the midpoint of the 0..1 segment: 123 + floor(319*128/256).
  function automatic bit ref_sp(input logic [15:0] e, output logic [15:0] y);
    y = 16'h0000;
    case (e)
      16'hF900: y = 16'h0000;
      16'hFE00: y = 16'h0004;
      16'hFF00: y = 16'h0019;
      16'h0000: y = 16'h007B;
      16'h0080: y = 16'h011A;
      16'h0100: y = 16'h01BA;
      16'h0200: y = 16'h0486;
      16'h0700: y = 16'h3103;
      default:  return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Handshake observer: every accepted operand pushes its expected result.
  always @(negedge clock) begin
    exp_t        e;
    logic [15:0] x;
    logic [15:0] ef;
    logic [15:0] y;
    if (rst) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
      end
      for (int g = 0; g < N; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          x  = req_data[g*W +: W];
          ef = eff_in(x);
          if (!ref_sp(ef, y)) begin
            errors++;
            $display("FAIL no_reference: operand %h has no reference value", x);
          end
          e.tag    = TW'(g);
          e.data   = y;
          e.sat    = (ef != x);
          e.hs_cyc = cyc;
          e.lat    = lat_mode;
          sb.push_back(e);
          acc_tags.push_back(g);
          acc_cycs.push_back(cyc);
          acc_total++;
        end
      end
    end
  end

  // Result monitor.
  always @(negedge clock) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      out_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: tag=%0d data=%h with nothing outstanding", out_tag, out_data);
      end else begin
        e = sb.pop_front();
        if (out_tag !== e.tag || out_data !== e.data || out_sat !== e.sat) begin
          errors++;
          $display("FAIL result: got tag=%0d data=%h sat=%b, expected tag=%0d data=%h sat=%b",
                   out_tag, out_data, out_sat, e.tag, e.data, e.sat);
        end
        if (e.lat) begin
          checks++;
          if (cyc - e.hs_cyc != 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected 2", cyc - e.hs_cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    sat_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    sb.delete();
    acc_tags.delete();
    acc_cycs.delete();
  endtask

  task automatic send(input int g, input logic [15:0] x);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    req_data[g*W +: W] = x;
    req_valid[g] = 1'b1;
    while (!done && n < 50) begin
      @(negedge clock);
      if (req_ready[g]) done = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    req_valid[g] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: requester %0d never granted", g);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    logic [15:0] clamp_vec [6];
    logic [15:0] bp_vec [3];
    int          n;
    int          base;
    int          oc0;

    // Reset state, sampled while reset is held.
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_tag",   32'(out_tag),   32'h0);
    chk("rst_out_sat",   32'(out_sat),   32'h0);
    chk("rst_sat_count", 32'(sat_count), 32'h0);
    do_reset();

    // Single requests with latency checking.
    lat_mode = 1'b1;
    send(2, 16'h0000);
    wait_drain(20);
    send(1, 16'h0080);
    wait_drain(20);

    // All four continuously valid: round-robin from pointer 0, no bubbles.
    do_reset();
    req_data  = {16'hFE00, 16'hFF00, 16'h0200, 16'h0100};
    req_valid = 4'hF;
    n = 0;
    while (acc_tags.size() < 8 && n < 40) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_drain(20);
    chk("rr_accepts", 32'(acc_tags.size()), 32'd8);
    if (acc_tags.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("rr_order", 32'(acc_tags[i]), 32'(i % 4));
        chk("rr_back_to_back", 32'(acc_cycs[i] - acc_cycs[0]), 32'(i));
      end
    end
    lat_mode = 1'b0;

    // Clamp window including both edges.
    do_reset();
    clamp_vec = '{16'h8000, 16'hF8FF, 16'hF900, 16'h0700, 16'h0701, 16'h7FFF};
    for (int i = 0; i < 6; i++) begin
      send(0, clamp_vec[i]);
    end
    wait_drain(20);
    chk("clamp_sat_count", 32'(sat_count), 32'd4);

    // Backpressure: two accepts fill S1 and S2, then everything stalls.
    do_reset();
    bp_vec = '{16'h0000, 16'h0100, 16'h0200};
    out_ready = 1'b0;
    req_data[W-1:0] = bp_vec[0];
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc_tags.size() < 3) req_data[W-1:0] = bp_vec[acc_tags.size()];
    end
    chk("bp_accepts", 32'(acc_tags.size()), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'h0);
    req_valid = '0;
    oc0 = out_count;
    out_ready = 1'b1;
    wait_drain(20);
    chk("bp_outputs", 32'(out_count - oc0), 32'd2);

    // Asynchronous reset with both stages full.
    do_reset();
    out_ready = 1'b0;
    req_data[W-1:0] = 16'h7FFF;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (acc_tags.size() >= 1) req_data[W-1:0] = 16'h8000;
      if (acc_tags.size() >= 2) req_valid[0] = 1'b0;
    end
    chk("pre_rst_sat_count", 32'(sat_count), 32'd2);
    chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_sat_count", 32'(sat_count), 32'h0);
    chk("async_rst_out_data",  32'(out_data),  32'h0);
    sb.delete();
    acc_tags.delete();
    acc_cycs.delete();
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 32'(out_valid), 32'h0);
    end
    req_data[1*W +: W] = 16'h0000;
    req_data[3*W +: W] = 16'h0100;
    req_valid = 4'b1010;
    n = 0;
    while (acc_tags.size() < 2 && n < 20) begin
      tick();
      foreach (acc_tags[k]) req_valid[acc_tags[k]] = 1'b0;
      n++;
    end
    req_valid = '0;
    wait_drain(20);
    chk("post_rst_accepts", 32'(acc_tags.size()), 32'd2);
    if (acc_tags.size() >= 2) begin
      chk("post_rst_first", 32'(acc_tags[0]), 32'd1);
      chk("post_rst_second", 32'(acc_tags[1]), 32'd3);
    end

    // sat_clr against a same-cycle clamped accept.
    do_reset();
    send(0, 16'h7FFF);
    wait_drain(20);
    chk("satclr_pre", 32'(sat_count), 32'd1);
    req_data[W-1:0] = 16'h8000;
    req_valid[0] = 1'b1;
    sat_clr = 1'b1;
    @(negedge clock);
    chk("satclr_accept", 32'(req_ready[0]), 32'h1);
    tick();
    req_valid = '0;
    sat_clr = 1'b0;
    chk("satclr_result", 32'(sat_count), 32'h0);
    wait_drain(20);

    // Saturation of sat_count.
    req_data[W-1:0] = 16'h7FFF;
    req_valid[0] = 1'b1;
    base = acc_total;
    n = 0;
    while ((acc_total - base) < 65540 && n < 70000) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_drain(20);
    chk("flood_accepts", 32'(acc_total - base), 32'd65540);
    chk("flood_sat_count", 32'(sat_count), 32'hFFFF);

    finish_sim();
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

endmodule
`default_nettype wire
